// File: rtl/arith_expr_seq_pkg.sv
// Shared FSM encoding and width helpers for the arith_expr_seq evaluator.
package arith_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV  = 3'd1,
        ST_MUL1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Result width: W-bit quotient * (W+1)-bit sum * (W+1)-bit signed difference.
    function automatic int unsigned p_w_of(input int unsigned w);
        return 3 * w + 3;
    endfunction

endpackage

// File: rtl/arith_expr_seq_if.sv
// Operand/result handshake bundle for arith_expr_seq; master drives operands, slave is the evaluator.
interface arith_expr_seq_if #(
    parameter int unsigned W = 8
);
    localparam int unsigned P_W = arith_pkg::p_w_of(W);

    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          A;
    logic [W-1:0]          B;
    logic [W-1:0]          C;
    logic [W-1:0]          D;
    logic [W-1:0]          E;
    logic [W-1:0]          F;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [P_W-1:0] P;
    logic                  div_zero;

    modport master (
        output in_valid, A, B, C, D, E, F, out_ready,
        input  in_ready, out_valid, P, div_zero
    );

    modport slave (
        input  in_valid, A, B, C, D, E, F, out_ready,
        output in_ready, out_valid, P, div_zero
    );

endinterface

// File: rtl/arith_expr_seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, W cycles per operation.
// A zero divisor never fails the trial subtract, so the quotient comes out all ones.
module seq_divider #(
    parameter int unsigned W = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic         div_zero
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] cnt;
    logic [W-1:0]  rem;
    logic [W-1:0]  quot_sr;
    logic [W-1:0]  dsor;
    logic [W:0]    shifted;
    logic          fits;

    assign shifted  = {rem, quot_sr[W-1]};
    assign fits     = (shifted >= {1'b0, dsor});
    assign busy     = (cnt != '0);
    // High during the cycle whose closing edge produces the last quotient bit.
    assign done     = (cnt == CW'(1));
    assign quotient = quot_sr;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt      <= '0;
            rem      <= '0;
            quot_sr  <= '0;
            dsor     <= '0;
            div_zero <= 1'b0;
        end else if (start) begin
            cnt      <= CW'(W);
            rem      <= '0;
            quot_sr  <= dividend;
            dsor     <= divisor;
            div_zero <= (divisor == '0);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (fits) begin
                rem     <= W'(shifted - {1'b0, dsor});
                quot_sr <= {quot_sr[W-2:0], 1'b1};
            end else begin
                rem     <= shifted[W-1:0];
                quot_sr <= {quot_sr[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/arith_expr_seq.sv
// Sequential evaluator of P = (A / B) * (C + D) * (E - F): valid/ready operand port,
// W-cycle restoring divide, two registered multiply stages, result held until taken.
module arith_expr_seq
    import arith_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input logic             sys_clk,
    input logic             sys_rst,
    arith_expr_seq_if.slave bus
);
    localparam int unsigned P_W  = p_w_of(W);
    localparam int unsigned S1_W = 2 * W + 1;

    state_t state;
    state_t state_next;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic s1_load;
    logic p_load;

    logic [W-1:0] c_q;
    logic [W-1:0] d_q;
    logic [W-1:0] e_q;
    logic [W-1:0] f_q;

    logic [W:0]            add;
    logic signed [W:0]     sub;
    logic [S1_W-1:0]       s1;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] p_q;
    logic                  dz_q;

    logic         div_busy;
    logic         div_done;
    logic         div_dz;
    logic [W-1:0] quot;

    // A and B are captured inside the divider on the accept edge.
    seq_divider #(
        .W (W)
    ) u_div (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (accept),
        .dividend (bus.A),
        .divisor  (bus.B),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot),
        .div_zero (div_dz)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept)        state_next = ST_DIV;
            ST_DIV:  if (div_done)      state_next = ST_MUL1;
            ST_MUL1:                    state_next = ST_MUL2;
            ST_MUL2:                    state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        s1_load   = 1'b0;
        p_load    = 1'b0;
        unique case (state)
            ST_IDLE: in_ready  = !div_busy;
            ST_MUL1: s1_load   = 1'b1;
            ST_MUL2: p_load    = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    assign add  = {1'b0, c_q} + {1'b0, d_q};
    assign sub  = $signed({1'b0, e_q}) - $signed({1'b0, f_q});
    // s1 is an unsigned magnitude; a zero MSB makes it a non-negative signed factor.
    assign prod = P_W'($signed({1'b0, s1})) * P_W'(sub);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            c_q  <= '0;
            d_q  <= '0;
            e_q  <= '0;
            f_q  <= '0;
            s1   <= '0;
            p_q  <= '0;
            dz_q <= 1'b0;
        end else begin
            if (accept) begin
                c_q <= bus.C;
                d_q <= bus.D;
                e_q <= bus.E;
                f_q <= bus.F;
            end
            if (s1_load) begin
                s1 <= S1_W'(quot) * S1_W'(add);
            end
            if (p_load) begin
                p_q  <= prod;
                dz_q <= div_dz;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.P         = p_q;
    assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_arith_expr_seq.sv
// Scoreboard bench for arith_expr_seq at W=8: directed operand sets with hand-computed
// results queued at issue time, checked by an independent output monitor.
module tb_arith_expr_seq;
    localparam int unsigned W   = 8;
    localparam int unsigned P_W = 3 * W + 3;
    localparam int          LAT = 10;

    typedef struct {
        logic signed [P_W-1:0] p;
        logic                  dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_hs = -100;
    exp_t exp_q[$];
    int   acc_q[$];
    exp_t mon_e;
    logic prev_ov = 1'b0;

    arith_expr_seq_if #(.W(W)) bus ();

    arith_expr_seq #(.W(W)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired with no DUT response (cycle %0d)", name, cyc);
    endtask

    // Monitor: latency from accept edge to out_valid rise, and result on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
            if (bus.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) check("accept_seen", acc_q.size(), 1);
                else check("latency", cyc - acc_q.pop_front(), LAT);
            end
            if (bus.out_valid && bus.out_ready) begin
                last_hs = cyc + 1;
                if (exp_q.size() == 0) begin
                    check("expected_pending", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("P", bus.P, mon_e.p);
                    check("div_zero", bus.div_zero, mon_e.dz);
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic wait_accept(output int acc_cyc);
        acc_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) fail_now("accept_timeout");
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] d, input logic [W-1:0] e, input logic [W-1:0] f,
                         input longint p, input logic dz, input bit expect_out,
                         output int acc_cyc);
        exp_t x;
        bus.A = a; bus.B = b; bus.C = c; bus.D = d; bus.E = e; bus.F = f;
        bus.in_valid = 1'b1;
        if (expect_out) begin
            x.p  = P_W'(p);
            x.dz = dz;
            exp_q.push_back(x);
        end
        wait_accept(acc_cyc);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int acc2;
        int n;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0; bus.E = '0; bus.F = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_P", bus.P, 0);
        check("rst_div_zero", bus.div_zero, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // basic: 14 * 7 * 8
        issue(100, 7, 3, 4, 10, 2, 784, 1'b0, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_drain();

        // negative: 20 * 510 * -255
        issue(200, 10, 255, 255, 0, 255, -2601000, 1'b0, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_drain();

        // divide by zero: quotient 255 * 1 * 1
        issue(5, 0, 1, 0, 1, 0, 255, 1'b1, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_drain();

        // back-pressure: 15 * 17 * -4, held for 5 cycles while new operands are offered
        bus.out_ready = 1'b0;
        issue(255, 16, 9, 8, 3, 7, -1020, 1'b0, 1'b1, acc);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail_now("bp_out_valid_timeout");
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.A = 8'd1; bus.B = 8'd1; bus.C = 8'd1; bus.D = 8'd1; bus.E = 8'd2; bus.F = 8'd1;
            bus.in_valid = (i % 2 == 0);
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_P", bus.P, -1020);
            check("bp_div_zero", bus.div_zero, 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        check("bp_idle_in_ready", bus.in_ready, 1);
        check("bp_single_output", bus.out_valid, 0);

        // reset four edges into the divide; the aborted set produces nothing
        issue(100, 7, 3, 4, 10, 2, 0, 1'b0, 1'b0, acc);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_P", bus.P, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_div_zero", bus.div_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(100, 7, 3, 4, 10, 2, 784, 1'b0, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_drain();

        // back-to-back with in_valid held: 5*2*1, then 255*510*255
        issue(17, 3, 1, 1, 6, 5, 10, 1'b0, 1'b1, acc);
        issue(255, 1, 255, 255, 255, 0, 33162750, 1'b0, 1'b1, acc2);
        check("b2b_accept_gap", acc2 - last_hs, 1);
        bus.in_valid = 1'b0;
        wait_drain();

        // most negative result and a zero quotient
        issue(255, 1, 255, 255, 0, 255, -33162750, 1'b0, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_drain();
        issue(3, 200, 255, 255, 255, 0, 0, 1'b0, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        check("end_out_valid", bus.out_valid, 0);
        check("end_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
